// File: rtl/mips_16_imem_loader.sv
// -----------------------------------------------------------------------------
// mips_16_imem_loader
//
// Writer side of the mips_16 instruction memory. A host streams a program
// image as bytes over a valid/ready link; the loader assembles 16-bit
// instruction words and writes them into the instruction memory that
// IF_stage fetches from. The core is held in reset (core_hold=1) until a
// complete image whose XOR checksum matches has been loaded.
//
// Stream format (little-endian):
//   len_lo, len_hi, {word_lo, word_hi} x len, checksum
//   checksum = XOR of all data bytes (length bytes excluded).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   load_start   single-cycle request to begin a load (sampled in IDLE/ERR)
//   in_data      stream byte
//   in_valid     in_data valid this cycle
//   in_ready     loader accepts a byte this cycle
//   imem_we      one-cycle write pulse per instruction word
//   imem_addr    write address
//   imem_wdata   write data
//   core_hold    drives the core's reset; 1 holds the core in reset
//   busy         a load is in progress
//   done         one-cycle pulse on successful completion
//   error        sticky load-failure flag (cleared by the next load_start)
//   words_loaded words written during the current or last load
//
// All outputs are registered. in_ready is registered from the next state so
// it is high exactly while the FSM sits in a byte-consuming state.
// -----------------------------------------------------------------------------
module mips_16_imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  // Number of words in the instruction memory, widened so that a length of
  // exactly DEPTH is representable next to the 16-bit length field.
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    CHK     = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Datapath registers (not reset: each is rewritten before it is used).
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  csum_q, csum_d;

  // Next values of the registered outputs.
  logic                  in_ready_d;
  logic                  imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_d;
  logic                  core_hold_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  error_d;
  logic [ADDR_WIDTH:0]   words_loaded_d;

  logic        accept;
  logic        start_ok;
  logic [15:0] len_rx;
  logic        len_bad;
  logic        last_word;
  logic        csum_ok;

  // A length of zero or one larger than the memory can never be loaded.
  function automatic logic len_invalid(input logic [15:0] len);
    return (len == 16'd0) || ({1'b0, len} > DEPTH);
  endfunction

  // A state is byte-consuming when it expects the next stream byte.
  function automatic logic consumes_byte(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
           (s == DATA_HI) || (s == CHK);
  endfunction

  assign accept    = in_valid && in_ready;
  // Only IDLE and ERR listen to load_start; everywhere else it is ignored.
  assign start_ok  = load_start && ((state_q == IDLE) || (state_q == ERR));
  assign len_rx    = {in_data, len_lo_q};
  assign len_bad   = len_invalid(len_rx);
  // words_loaded equals the index of the word being completed.
  assign last_word = ((16'(words_loaded) + 16'd1) == len_q);
  assign csum_ok   = (in_data == csum_q);

  // ---- State register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- Next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LEN_LO;
      LEN_LO:  if (accept)   state_d = LEN_HI;
      LEN_HI:  if (accept)   state_d = len_bad ? ERR : DATA_LO;
      DATA_LO: if (accept)   state_d = DATA_HI;
      DATA_HI: if (accept)   state_d = last_word ? CHK : DATA_LO;
      CHK:     if (accept)   state_d = csum_ok ? DONE : ERR;
      DONE:                  state_d = IDLE;
      ERR:     if (start_ok) state_d = LEN_LO;
      default:               state_d = IDLE;
    endcase
  end

  // ---- Output / datapath next-value logic ----
  always_comb begin
    len_lo_d       = len_lo_q;
    len_d          = len_q;
    lo_d           = lo_q;
    csum_d         = csum_q;
    in_ready_d     = consumes_byte(state_d);
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr;
    imem_wdata_d   = imem_wdata;
    core_hold_d    = core_hold;
    busy_d         = busy;
    done_d         = 1'b0;
    error_d        = error;
    words_loaded_d = words_loaded;

    case (state_q)
      IDLE, ERR: begin
        if (start_ok) begin
          busy_d         = 1'b1;
          core_hold_d    = 1'b1;
          error_d        = 1'b0;
          words_loaded_d = '0;
          csum_d         = 8'd0;
        end
      end
      LEN_LO: begin
        if (accept) len_lo_d = in_data;
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_rx;
          if (len_bad) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      DATA_LO: begin
        if (accept) begin
          lo_d   = in_data;
          csum_d = csum_q ^ in_data;
        end
      end
      DATA_HI: begin
        // The write is issued from the register stage, so it lands in the
        // cycle after the high byte is accepted and never waits on CHK.
        if (accept) begin
          csum_d         = csum_q ^ in_data;
          imem_we_d      = 1'b1;
          imem_addr_d    = words_loaded[ADDR_WIDTH-1:0];
          imem_wdata_d   = {in_data, lo_q};
          words_loaded_d = words_loaded + 1'b1;
        end
      end
      CHK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (csum_ok) begin
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // ---- Output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      in_ready     <= in_ready_d;
      imem_we      <= imem_we_d;
      imem_addr    <= imem_addr_d;
      imem_wdata   <= imem_wdata_d;
      core_hold    <= core_hold_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= words_loaded_d;
    end
  end

  // ---- Datapath registers ----
  always_ff @(posedge clk) begin
    len_lo_q <= len_lo_d;
    len_q    <= len_d;
    lo_q     <= lo_d;
    csum_q   <= csum_d;
  end

endmodule

// File: doc/mips_16_imem_loader.md
Name: mips_16_imem_loader

Overview:
- Writer side of the mips_16 instruction memory: receives a program as a byte stream over a valid/ready link and writes 16-bit instruction words into the instruction memory that IF_stage fetches from.
- Holds the core in reset until a complete, checksum-verified image is loaded.
- Sits between the bench/host byte source and the instruction memory write port, beside mips_16_core_top.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width; equals `PC_WIDTH. DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction word width. Fixed at 16; other values are unsupported.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- load_start, input, 1, single-cycle request to begin a new load.
- in_data, input, 8, stream byte.
- in_valid, input, 1, in_data is valid this cycle.
- in_ready, output, 1, loader accepts a byte this cycle.
- imem_we, output, 1, instruction memory write enable, one-cycle pulse per word.
- imem_addr, output, ADDR_WIDTH, write address.
- imem_wdata, output, 16, write data.
- core_hold, output, 1, drives the core's rst. High means the core is held in reset.
- busy, output, 1, a load is in progress.
- done, output, 1, one-cycle pulse when a load completes successfully.
- error, output, 1, sticky load-failure flag.
- words_loaded, output, ADDR_WIDTH+1, number of words written during the current or last load.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge) forces: state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, core_hold=1. Reset takes priority over every other event. Reset mid-load abandons the load; words already written stay in memory.
- Accept: a byte is consumed when in_valid && in_ready at the clock edge. in_data is don't-care otherwise.
- in_ready=1 exactly in states LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK. Back-to-back accepts are supported with no bubbles.
- States:
  - IDLE: load_start=1 -> LEN_LO. Entering LEN_LO sets busy=1 and core_hold=1, clears error, and clears words_loaded, the word index and the running checksum.
  - LEN_LO: accepted byte -> len[7:0], go to LEN_HI.
  - LEN_HI: accepted byte -> len[15:8]. If len==0 or len>DEPTH -> ERR. Otherwise -> DATA_LO.
  - DATA_LO: accepted byte -> lo register, csum ^= byte, go to DATA_HI.
  - DATA_HI: accepted byte -> csum ^= byte. Next cycle: imem_we=1, imem_addr=index, imem_wdata={byte,lo}. index and words_loaded increment. If index+1==len -> CHK, else -> DATA_LO.
  - CHK: accepted byte is compared with csum (the XOR of all data bytes; length bytes excluded). Match -> DONE. Mismatch -> ERR.
  - DONE (1 cycle): done=1, busy=0, core_hold=0, then -> IDLE.
  - ERR: error=1, busy=0, core_hold stays 1. Stays in ERR until load_start, which behaves as in IDLE.
- imem_we is 0 in every cycle other than the write cycle. imem_addr and imem_wdata hold their last values between writes.
- The address never wraps, because len is at most DEPTH. With len==DEPTH the last write address is DEPTH-1.
- load_start while busy=1 is ignored.
- A load_start arriving in the same cycle as the DONE transition is ignored. Only IDLE and ERR sample load_start.
- The loader does not stall the memory. A write issued in the cycle after the final DATA_HI accept completes regardless of the CHK byte timing.
- After a successful load, core_hold stays 0 until the next load_start or reset.

Test Plan:
- Basic load: load_start, then bytes 02 00 34 12 CD AB 40.
  - Required: writes addr0=0x1234 and addr1=0xABCD, one cycle each.
  - Required: done pulses once; core_hold goes 1->0; error=0; words_loaded=2.
- Bad checksum: same stream with final byte 0x41.
  - Required: both words are written; error=1; done is never asserted; core_hold stays 1; busy=0.
  - Required: a following load_start clears error.
- Length errors: len bytes 00 00, and separately 01 01 (257).
  - Required: ERR immediately after the LEN_HI accept; no imem_we pulses; in_ready=0 afterwards.
- Stall robustness: basic load with in_valid deasserted for random gaps of 0-5 cycles.
  - Required: the write sequence, done and words_loaded are identical to the basic load.
- Full depth: len=0x0100, data word k=k^0xA5A5 for k=0..255, correct checksum.
  - Required: 256 writes; last write at addr 0xFF with no wrap; words_loaded=256; done pulses.
- Reset and ignored start:
  - Pulse load_start again after 3 words. Required: ignored.
  - Assert rst for 1 cycle. Required: IDLE, in_ready=0, busy=0, core_hold=1, words_loaded=0.
  - Required: further in_valid bytes are not accepted until the next load_start.
